char_row_renderer: RTL and testbench

- Renders one 800-pixel scanline of text into the pixel buffer. Per character it fetches the code/attribute word from the character row buffer, the 8-pixel glyph slice from font memory, and the foreground and background colours from the palette.
- Sits upstream of pixbuf and downstream of chrowbuf/fontmem/palette. It replaces the hard-coded renderer in the top level, which pulses start once per scanline during the back porch.

---
 rtl/char_row_renderer.sv | 251 +++++++++++++++++++++++++
 tb/tb_char_row_renderer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_row_renderer.sv
// char_row_renderer
// Renders one scanline of text into the pixel buffer. For every character
// column it reads the code/attribute word from the character row buffer,
// the 8-pixel glyph slice from font memory and the foreground/background
// colours from the palette, then streams one pixel per clock into pixbuf.
//
// Ports
//   clk, nrst            40 MHz pixel clock, asynchronous active-low reset
//   start, pixel_row     1-cycle render request and the glyph row to draw
//   busy, done           scanline in progress / 1-cycle completion pulse
//   chrowbuf_rd*         character row buffer read (active-low strobe)
//   fontmem_rd*          font memory read (active-low strobe)
//   palette_rd*          palette read (active-low strobe)
//   pixbuf_wr*           pixel buffer write (active-low strobe)
module char_row_renderer #(
  parameter int NUM_COLS = 100,
  parameter int SLOT_LEN = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [3:0]  pixel_row,
  output logic        busy,
  output logic        done,
  output logic        chrowbuf_rd,
  output logic [7:0]  chrowbuf_rd_addr,
  input  logic [15:0] chrowbuf_rd_data,
  output logic        fontmem_rd,
  output logic [11:0] fontmem_rd_addr,
  input  logic [7:0]  fontmem_rd_data,
  output logic        palette_rd,
  output logic [7:0]  palette_rd_addr,
  input  logic [15:0] palette_rd_data,
  output logic        pixbuf_wr,
  output logic [9:0]  pixbuf_wr_addr,
  output logic [15:0] pixbuf_wr_data
);

  localparam int SubW = $clog2(SLOT_LEN);
  localparam logic [SubW-1:0] SubLast = SubW'(SLOT_LEN - 1);
  localparam logic [7:0] NumColsC = 8'(NUM_COLS);
  localparam logic [9:0] LastPix = 10'(NUM_COLS * 8 - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RENDER} state_t;

  state_t state_q, state_d;
  logic [SubW-1:0] sub_q, sub_d;
  logic [7:0]  colFetch_q, colFetch_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  bgIdx_q, bgIdx_d;
  logic [7:0]  glyphFetch_q, glyphFetch_d;
  logic [15:0] fgFetch_q, fgFetch_d;
  logic [15:0] bgFetch_q, bgFetch_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] fgOut_q, fgOut_d;
  logic [15:0] bgOut_q, bgOut_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        chrowRd_q, chrowRd_d;
  logic [7:0]  chrowAddr_q, chrowAddr_d;
  logic        fontRd_q, fontRd_d;
  logic [11:0] fontAddr_q, fontAddr_d;
  logic        palRd_q, palRd_d;
  logic [7:0]  palAddr_q, palAddr_d;
  logic        pixWr_q, pixWr_d;
  logic [9:0]  pixAddr_q, pixAddr_d;
  logic [15:0] pixData_q, pixData_d;

  logic        transfer;
  logic        writeNow;
  logic        fetchOk;
  logic [15:0] pix;

  // Every output strobe is registered, so strobes and addresses are derived
  // from the state/sub/column being entered (the _d values). The fontmem and
  // fg palette addresses come straight from the chrowbuf read data because
  // they are launched on the same edge that would otherwise capture it.
  // Colours are stored with [15:12] cleared so written pixels are {4'h0,RGB}.
  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    colFetch_d   = colFetch_q;
    row_d        = row_q;
    bgIdx_d      = bgIdx_q;
    glyphFetch_d = glyphFetch_q;
    fgFetch_d    = fgFetch_q;
    bgFetch_d    = bgFetch_q;
    shift_d      = shift_q;
    fgOut_d      = fgOut_q;
    bgOut_d      = bgOut_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    chrowRd_d    = 1'b1;
    chrowAddr_d  = chrowAddr_q;
    fontRd_d     = 1'b1;
    fontAddr_d   = fontAddr_q;
    palRd_d      = 1'b1;
    palAddr_d    = palAddr_q;
    pixWr_d      = 1'b1;
    pixAddr_d    = pixAddr_q;
    pixData_d    = pixData_q;
    transfer     = 1'b0;
    writeNow     = 1'b0;
    fetchOk      = 1'b0;
    pix          = 16'h0000;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = PRIME;
          row_d      = pixel_row;
          colFetch_d = 8'd0;
          sub_d      = '0;
        end
      end
      PRIME: begin
        sub_d = sub_q + 1'b1;
        if (sub_q == SubLast) begin
          state_d    = RENDER;
          colFetch_d = colFetch_q + 8'd1;
          transfer   = 1'b1;
          writeNow   = 1'b1;
          pixAddr_d  = 10'd0;
        end
      end
      RENDER: begin
        if (pixAddr_q == LastPix) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          sub_d     = sub_q + 1'b1;
          writeNow  = 1'b1;
          pixAddr_d = pixAddr_q + 10'd1;
          if (sub_q == SubLast) begin
            colFetch_d = colFetch_q + 8'd1;
            transfer   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (sub_q == SubW'(1)) bgIdx_d = chrowbuf_rd_data[15:12];
      if (sub_q == SubW'(3)) begin
        glyphFetch_d = fontmem_rd_data;
        fgFetch_d    = palette_rd_data & 16'h0FFF;
      end
      if (sub_q == SubW'(4)) bgFetch_d = palette_rd_data & 16'h0FFF;
    end

    // The first pixel of a column comes from the fetch registers on the same
    // edge that loads the output stage; later pixels come from the shifter.
    if (transfer) begin
      fgOut_d = fgFetch_q;
      bgOut_d = bgFetch_q;
      shift_d = {glyphFetch_q[6:0], 1'b0};
      pix     = glyphFetch_q[7] ? fgFetch_q : bgFetch_q;
    end else begin
      pix = shift_q[7] ? fgOut_q : bgOut_q;
      if (writeNow) shift_d = {shift_q[6:0], 1'b0};
    end

    if (writeNow) begin
      pixWr_d   = 1'b0;
      pixData_d = pix;
    end

    busy_d  = (state_d != IDLE);
    fetchOk = (state_d != IDLE) && (colFetch_d < NumColsC);
    if (fetchOk) begin
      if (sub_d == SubW'(0)) begin
        chrowRd_d   = 1'b0;
        chrowAddr_d = colFetch_d;
      end
      if (sub_d == SubW'(2)) begin
        fontRd_d   = 1'b0;
        fontAddr_d = {chrowbuf_rd_data[7:0], row_q};
        palRd_d    = 1'b0;
        palAddr_d  = {4'h0, chrowbuf_rd_data[11:8]};
      end
      if (sub_d == SubW'(3)) begin
        palRd_d   = 1'b0;
        palAddr_d = {4'h0, bgIdx_q};
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      sub_q        <= '0;
      colFetch_q   <= 8'd0;
      row_q        <= 4'd0;
      bgIdx_q      <= 4'd0;
      glyphFetch_q <= 8'd0;
      fgFetch_q    <= 16'h0000;
      bgFetch_q    <= 16'h0000;
      shift_q      <= 8'd0;
      fgOut_q      <= 16'h0000;
      bgOut_q      <= 16'h0000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      chrowRd_q    <= 1'b1;
      chrowAddr_q  <= 8'd0;
      fontRd_q     <= 1'b1;
      fontAddr_q   <= 12'd0;
      palRd_q      <= 1'b1;
      palAddr_q    <= 8'd0;
      pixWr_q      <= 1'b1;
      pixAddr_q    <= 10'd0;
      pixData_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      colFetch_q   <= colFetch_d;
      row_q        <= row_d;
      bgIdx_q      <= bgIdx_d;
      glyphFetch_q <= glyphFetch_d;
      fgFetch_q    <= fgFetch_d;
      bgFetch_q    <= bgFetch_d;
      shift_q      <= shift_d;
      fgOut_q      <= fgOut_d;
      bgOut_q      <= bgOut_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      chrowRd_q    <= chrowRd_d;
      chrowAddr_q  <= chrowAddr_d;
      fontRd_q     <= fontRd_d;
      fontAddr_q   <= fontAddr_d;
      palRd_q      <= palRd_d;
      palAddr_q    <= palAddr_d;
      pixWr_q      <= pixWr_d;
      pixAddr_q    <= pixAddr_d;
      pixData_q    <= pixData_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign chrowbuf_rd      = chrowRd_q;
  assign chrowbuf_rd_addr = chrowAddr_q;
  assign fontmem_rd       = fontRd_q;
  assign fontmem_rd_addr  = fontAddr_q;
  assign palette_rd       = palRd_q;
  assign palette_rd_addr  = palAddr_q;
  assign pixbuf_wr        = pixWr_q;
  assign pixbuf_wr_addr   = pixAddr_q;
  assign pixbuf_wr_data   = pixData_q;

endmodule

// File: tb/tb_char_row_renderer.sv
// tb_char_row_renderer
// Self-checking bench for char_row_renderer. Models the three 1-cycle-latency
// memories, pushes the expected pixel stream, font/row-buffer addresses and
// done timing into scoreboard queues whenever a row is requested, and pops
// and compares them as the DUT produces accesses.
module tb_char_row_renderer;

  localparam int NumCols = 100;
  localparam int NumPix  = NumCols * 8;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    int          cycle;
  } wrExp_t;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [3:0]  pixel_row;
  logic        busy;
  logic        done;
  logic        chrowbuf_rd;
  logic [7:0]  chrowbuf_rd_addr;
  logic [15:0] chrowbuf_rd_data;
  logic        fontmem_rd;
  logic [11:0] fontmem_rd_addr;
  logic [7:0]  fontmem_rd_data;
  logic        palette_rd;
  logic [7:0]  palette_rd_addr;
  logic [15:0] palette_rd_data;
  logic        pixbuf_wr;
  logic [9:0]  pixbuf_wr_addr;
  logic [15:0] pixbuf_wr_data;

  logic [15:0] chrowMem [256];
  logic [7:0]  fontMem [4096];
  logic [15:0] paletteMem [256];

  wrExp_t      writeQ[$];
  int          doneQ[$];
  logic [11:0] fontQ[$];
  logic [7:0]  chrowQ[$];

  int checkCount = 0;
  int failCount  = 0;
  int cycleCnt   = 0;

  char_row_renderer #(.NUM_COLS(NumCols), .SLOT_LEN(8)) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .pixel_row(pixel_row),
    .busy(busy),
    .done(done),
    .chrowbuf_rd(chrowbuf_rd),
    .chrowbuf_rd_addr(chrowbuf_rd_addr),
    .chrowbuf_rd_data(chrowbuf_rd_data),
    .fontmem_rd(fontmem_rd),
    .fontmem_rd_addr(fontmem_rd_addr),
    .fontmem_rd_data(fontmem_rd_data),
    .palette_rd(palette_rd),
    .palette_rd_addr(palette_rd_addr),
    .palette_rd_data(palette_rd_data),
    .pixbuf_wr(pixbuf_wr),
    .pixbuf_wr_addr(pixbuf_wr_addr),
    .pixbuf_wr_data(pixbuf_wr_data)
  );

  // Free-running pixel clock plus an edge counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Memories answer one cycle after an active-low read strobe.
  always @(posedge clk) begin
    if (!chrowbuf_rd) chrowbuf_rd_data <= chrowMem[chrowbuf_rd_addr];
    if (!fontmem_rd)  fontmem_rd_data  <= fontMem[fontmem_rd_addr];
    if (!palette_rd)  palette_rd_data  <= paletteMem[palette_rd_addr];
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request a row at the current negedge and push its expected output,
  // computed from the bench's own memory arrays.
  task automatic applyStimulus(input logic [3:0] row, input bit expectRow);
    int e0;
    logic [15:0] ent;
    logic [7:0]  g;
    logic [15:0] colour;
    wrExp_t      w;
    start     = 1'b1;
    pixel_row = row;
    if (expectRow) begin
      e0 = cycleCnt + 1;
      for (int c = 0; c < NumCols; c++) begin
        ent = chrowMem[c];
        chrowQ.push_back(8'(c));
        fontQ.push_back({ent[7:0], row});
        g = fontMem[{ent[7:0], row}];
        for (int b = 0; b < 8; b++) begin
          colour = g[7-b] ? paletteMem[{4'h0, ent[11:8]}] : paletteMem[{4'h0, ent[15:12]}];
          w.addr  = 10'(c * 8 + b);
          w.data  = {4'h0, colour[11:0]};
          w.cycle = e0 + 8 + c * 8 + b;
          writeQ.push_back(w);
        end
      end
      doneQ.push_back(e0 + 8 + NumPix);
    end
    @(negedge clk);
    start     = 1'b0;
    pixel_row = 4'($urandom_range(15));
  endtask

  // Wait (bounded) until every expected access of the pending rows was seen.
  task automatic waitIdle(input int budget);
    int n = 0;
    while ((writeQ.size() != 0 || doneQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rowTimeout", 32'(writeQ.size() + doneQ.size()), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the DUT edge.
  always @(negedge clk) begin : monitor
    wrExp_t e;
    if (nrst) begin
      if (!pixbuf_wr) begin
        if (writeQ.size() == 0) checkOutput("unexpectedWrite", 32'd1, 32'd0);
        else begin
          e = writeQ.pop_front();
          checkOutput("wrAddr", 32'(pixbuf_wr_addr), 32'(e.addr));
          checkOutput("wrData", 32'(pixbuf_wr_data), 32'(e.data));
          checkOutput("wrCycle", 32'(cycleCnt), 32'(e.cycle));
          checkOutput("busyWr", 32'(busy), 32'd1);
        end
      end
      if (done) begin
        if (doneQ.size() == 0) checkOutput("unexpectedDone", 32'd1, 32'd0);
        else begin
          checkOutput("doneCycle", 32'(cycleCnt), 32'(doneQ.pop_front()));
          checkOutput("busyAtDone", 32'(busy), 32'd0);
        end
      end
      if (!fontmem_rd) begin
        if (fontQ.size() == 0) checkOutput("unexpectedFontRd", 32'd1, 32'd0);
        else checkOutput("fontAddr", 32'(fontmem_rd_addr), 32'(fontQ.pop_front()));
      end
      if (!chrowbuf_rd) begin
        if (chrowQ.size() == 0) checkOutput("unexpectedChrowRd", 32'd1, 32'd0);
        else checkOutput("chrowAddr", 32'(chrowbuf_rd_addr), 32'(chrowQ.pop_front()));
      end
    end
  end

  // Pattern A: every column is code 8'h41, fg index 1, bg index 2.
  task automatic loadPatternA();
    for (int i = 0; i < 4096; i++) fontMem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      chrowMem[i]   = 16'h2141;
      paletteMem[i] = 16'h0000;
    end
    fontMem[12'h413] = 8'b1010_0000;
    paletteMem[1]    = 16'h0FF0;
    paletteMem[2]    = 16'h0006;
  endtask

  // Pattern B: code = column, per-column colours, palette alpha nibble set.
  task automatic loadPatternB();
    for (int i = 0; i < 4096; i++) fontMem[i] = 8'(i * 13 + 7);
    for (int i = 0; i < 256; i++) begin
      chrowMem[i]   = {4'(i + 3), 4'(i), 8'(i)};
      paletteMem[i] = {4'hA, 12'(i * 273 + 5)};
    end
  endtask

  initial begin : stimulus
    int n;
    nrst      = 1'b0;
    start     = 1'b0;
    pixel_row = 4'd0;
    chrowbuf_rd_data = 16'h0;
    fontmem_rd_data  = 8'h0;
    palette_rd_data  = 16'h0;
    loadPatternA();
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstStrobes", 32'({chrowbuf_rd, fontmem_rd, palette_rd, pixbuf_wr}), 32'hF);
    checkOutput("rstAddrs", 32'({chrowbuf_rd_addr, fontmem_rd_addr, palette_rd_addr, pixbuf_wr_addr}) , 32'd0);
    checkOutput("rstData", 32'(pixbuf_wr_data), 32'd0);
    nrst = 1'b1;

    // Idle with no start: nothing may move.
    repeat (20) begin
      @(negedge clk);
      checkOutput("idleStrobes", 32'({chrowbuf_rd, fontmem_rd, palette_rd, pixbuf_wr}), 32'hF);
      checkOutput("idleBusyDone", 32'({busy, done}), 32'd0);
    end

    // Fixed glyph pattern, row 3.
    applyStimulus(4'd3, 1'b1);
    waitIdle(2000);

    // Per-column data, spurious starts at E0+5 and E0+300, then a start
    // coincident with done for a back-to-back row.
    loadPatternB();
    applyStimulus(4'd5, 1'b1);
    repeat (4) @(negedge clk);
    applyStimulus(4'd9, 1'b0);
    repeat (294) @(negedge clk);
    applyStimulus(4'd1, 1'b0);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("waitFirstDone", 32'(done), 32'd1);
    applyStimulus(4'd9, 1'b1);
    waitIdle(2000);

    // Abort mid-row with reset, then render a full row again.
    applyStimulus(4'd7, 1'b1);
    n = 0;
    while (!(!pixbuf_wr && pixbuf_wr_addr == 10'd400) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachAddr400", 32'(pixbuf_wr_addr), 32'd400);
    #2;
    nrst = 1'b0;
    #1;
    writeQ.delete();
    doneQ.delete();
    fontQ.delete();
    chrowQ.delete();
    checkOutput("abortStrobes", 32'({chrowbuf_rd, fontmem_rd, palette_rd, pixbuf_wr}), 32'hF);
    checkOutput("abortBusyDone", 32'({busy, done}), 32'd0);
    @(negedge clk);
    #2;
    nrst = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(4'd2, 1'b1);
    waitIdle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
